// File: rtl/rc4_pkg.sv
// rc4_pkg: shared types and constants for the RC4 keystream sequencer.
//   state_e : sequencer states (key load, S-box init, KSA, PRGA)
//   SBOX_N  : S-box depth
//   BYTE_W  : data width of key, S-box and keystream bytes
package rc4_pkg;

    localparam int SBOX_N = 256;
    localparam int BYTE_W = 8;

    typedef enum logic [3:0] {
        IDLE, KLOAD, INIT,
        K_RI, K_RJ, K_WI, K_WJ,
        P_RI, P_RJ, P_WI, P_WJ, P_RT, P_CAP, P_WAIT
    } state_e;

endpackage

// File: rtl/rc4_keybuf.sv
// rc4_keybuf: KEY_MAX x 8 key register file.
//   clk, rst  : clock, synchronous active-high reset (clears bytes and length)
//   we_i      : append wdata_i at the current length; ignored once full
//   wdata_i   : key byte to store
//   idx_i     : cipher index i; read port returns key[i mod key_len]
//   rdata_o   : combinational key byte
module rc4_keybuf
    import rc4_pkg::*;
#(
    parameter int KEY_MAX = 32,
    parameter int KEY_AW  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [BYTE_W-1:0] wdata_i,
    input  logic [BYTE_W-1:0] idx_i,
    output logic [BYTE_W-1:0] rdata_o
);

    logic [BYTE_W-1:0] mem_q [KEY_MAX];
    logic [KEY_AW:0]   len_q;
    logic [BYTE_W-1:0] len8;

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q <= '0;
            for (int k = 0; k < KEY_MAX; k++) mem_q[k] <= '0;
        end else if (we_i && (len_q < (KEY_AW+1)'(KEY_MAX))) begin
            mem_q[len_q[KEY_AW-1:0]] <= wdata_i;
            len_q                    <= len_q + 1'b1;
        end
    end

    // Length is never 0 while the index is consumed; the guard only keeps
    // the modulo well-defined in IDLE.
    always_comb begin
        len8    = (len_q == '0) ? 8'd1 : 8'(len_q);
        rdata_o = mem_q[KEY_AW'(idx_i % len8)];
    end

endmodule

// File: rtl/rc4_sched.sv
// rc4_sched: RC4 sequencer. Owns i/j and all S-box RAM traffic; runs key
// load, S-box init, KSA, then PRGA, and hands keystream bytes out over a
// valid/ready handshake.
//   clk, rst            : clock, synchronous active-high reset
//   key_valid, key_in   : key byte stream (accepted in IDLE/KLOAD only)
//   restart             : re-run INIT+KSA from the stored key
//   sb_addr/we/wdata    : S-box RAM write/read port
//   sb_rdata            : S-box read data, one cycle after sb_addr
//   ks_valid/data/ready : keystream handshake
//   keyed, busy         : PRGA-active / key-setup-active status
// Build option: RC4_DROP_EN discards the first DROP_N bytes after each KSA.
module rc4_sched
    import rc4_pkg::*;
#(
    parameter int KEY_MAX = 32,
    parameter int KEY_AW  = 5,
    parameter int DROP_N  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_valid,
    input  logic [BYTE_W-1:0] key_in,
    input  logic              restart,
    output logic [BYTE_W-1:0] sb_addr,
    output logic              sb_we,
    output logic [BYTE_W-1:0] sb_wdata,
    input  logic [BYTE_W-1:0] sb_rdata,
    output logic              ks_valid,
    output logic [BYTE_W-1:0] ks_data,
    input  logic              ks_ready,
    output logic              keyed,
    output logic              busy
);

    localparam logic [BYTE_W-1:0] LAST = 8'(SBOX_N - 1);

    if (DROP_N > 511) begin : g_drop_chk
        $error("DROP_N does not fit the 9-bit drop counter");
    end

    state_e            state_q, state_d;
    logic [BYTE_W-1:0] i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
    logic [BYTE_W-1:0] ks_data_q, ks_data_d;
    logic              ks_valid_q, ks_valid_d;
    logic              key_we;
    logic [BYTE_W-1:0] key_byte;
`ifdef RC4_DROP_EN
    logic [8:0]        drop_q, drop_d;
`endif

    rc4_keybuf #(.KEY_MAX(KEY_MAX), .KEY_AW(KEY_AW)) u_keybuf (
        .clk     (clk),
        .rst     (rst),
        .we_i    (key_we),
        .wdata_i (key_in),
        .idx_i   (i_q),
        .rdata_o (key_byte)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            i_q        <= '0;
            j_q        <= '0;
            si_q       <= '0;
            sj_q       <= '0;
            ks_data_q  <= '0;
            ks_valid_q <= 1'b0;
`ifdef RC4_DROP_EN
            drop_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            si_q       <= si_d;
            sj_q       <= sj_d;
            ks_data_q  <= ks_data_d;
            ks_valid_q <= ks_valid_d;
`ifdef RC4_DROP_EN
            drop_q     <= drop_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        j_d        = j_q;
        si_d       = si_q;
        sj_d       = sj_q;
        ks_data_d  = ks_data_q;
        ks_valid_d = ks_valid_q;
        key_we     = 1'b0;
        sb_addr    = '0;
        sb_we      = 1'b0;
        sb_wdata   = '0;
`ifdef RC4_DROP_EN
        drop_d     = drop_q;
`endif
        case (state_q)
            IDLE: if (key_valid) begin
                key_we  = 1'b1;
                state_d = KLOAD;
            end
            KLOAD: if (key_valid) begin
                key_we = 1'b1;
            end else begin
                state_d = INIT;
                i_d     = '0;
                j_d     = '0;
`ifdef RC4_DROP_EN
                drop_d  = '0;
`endif
            end
            INIT: begin
                sb_we    = 1'b1;
                sb_addr  = i_q;
                sb_wdata = i_q;
                i_d      = i_q + 8'd1;   // wraps to 0 for KSA
                if (i_q == LAST) begin
                    j_d     = '0;
                    state_d = K_RI;
                end
            end
            K_RI: begin
                sb_addr = i_q;
                state_d = K_RJ;
            end
            K_RJ: begin
                si_d    = sb_rdata;
                j_d     = j_q + sb_rdata + key_byte;
                sb_addr = j_d;
                state_d = K_WI;
            end
            K_WI: begin
                sb_we    = 1'b1;
                sb_addr  = i_q;
                sb_wdata = sb_rdata;     // S[j]
                state_d  = K_WJ;
            end
            K_WJ: begin
                sb_we    = 1'b1;
                sb_addr  = j_q;
                sb_wdata = si_q;
                i_d      = i_q + 8'd1;
                state_d  = K_RI;
                if (i_q == LAST) begin
                    i_d     = '0;
                    j_d     = '0;
                    state_d = P_RI;
                end
            end
            P_RI: begin
                i_d     = i_q + 8'd1;
                sb_addr = i_d;
                state_d = P_RJ;
            end
            P_RJ: begin
                si_d    = sb_rdata;
                j_d     = j_q + sb_rdata;
                sb_addr = j_d;
                state_d = P_WI;
            end
            P_WI: begin
                sj_d     = sb_rdata;
                sb_we    = 1'b1;
                sb_addr  = i_q;
                sb_wdata = sb_rdata;
                state_d  = P_WJ;
            end
            P_WJ: begin
                sb_we    = 1'b1;
                sb_addr  = j_q;
                sb_wdata = si_q;
                state_d  = P_RT;
            end
            P_RT: begin
                sb_addr = si_q + sj_q;
                state_d = P_CAP;
            end
            P_CAP: begin
`ifdef RC4_DROP_EN
                if (drop_q < 9'(DROP_N)) begin
                    drop_d  = drop_q + 9'd1;
                    state_d = P_RI;
                end else begin
                    ks_data_d  = sb_rdata;
                    ks_valid_d = 1'b1;
                    state_d    = P_WAIT;
                end
`else
                ks_data_d  = sb_rdata;
                ks_valid_d = 1'b1;
                state_d    = P_WAIT;
`endif
            end
            P_WAIT: if (ks_ready) begin
                ks_valid_d = 1'b0;
                state_d    = P_RI;
            end
            default: state_d = IDLE;
        endcase

        // Restart overrides everything, including a same-cycle handshake:
        // the pending byte is dropped and counts as undelivered.
        if (restart && state_q != IDLE && state_q != KLOAD) begin
            state_d    = INIT;
            i_d        = '0;
            j_d        = '0;
            ks_valid_d = 1'b0;
`ifdef RC4_DROP_EN
            drop_d     = '0;
`endif
        end
    end

    assign ks_valid = ks_valid_q;
    assign ks_data  = ks_data_q;
    assign keyed    = (state_q inside {P_RI, P_RJ, P_WI, P_WJ, P_RT, P_CAP, P_WAIT});
    assign busy     = (state_q inside {KLOAD, INIT, K_RI, K_RJ, K_WI, K_WJ});

endmodule

// File: tb/tb_rc4_sched.sv
module tb_rc4_sched;
    import rc4_pkg::*;

    logic       clk = 1'b0;
    logic       rst, key_valid, restart, ks_ready;
    logic [7:0] key_in;
    logic [7:0] sb_addr, sb_wdata, ks_data;
    logic [7:0] sb_rdata = 8'h00;
    logic       sb_we, ks_valid, keyed, busy;

    rc4_sched dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_in(key_in),
        .restart(restart), .sb_addr(sb_addr), .sb_we(sb_we), .sb_wdata(sb_wdata),
        .sb_rdata(sb_rdata), .ks_valid(ks_valid), .ks_data(ks_data),
        .ks_ready(ks_ready), .keyed(keyed), .busy(busy)
    );

    always #5 clk = ~clk;

    // S-box RAM, synchronous read
    logic [7:0] ram [256];
    always @(posedge clk) begin
        if (sb_we) ram[sb_addr] <= sb_wdata;
        sb_rdata <= ram[sb_addr];
    end

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] kbuf [64];
    logic [7:0] got [16];
    logic [7:0] exp_ks [16];
    logic [7:0] key_ks [10]  = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
    logic [7:0] wiki_ks [5]  = '{8'h60, 8'h44, 8'hDB, 8'h6D, 8'h41};
    logic       b_1279, b_1280, k_1280;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; key_valid = 1'b0; key_in = 8'h00; restart = 1'b0; ks_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic set_key_str(input int which);
        if (which == 0) begin
            kbuf[0] = 8'h4B; kbuf[1] = 8'h65; kbuf[2] = 8'h79;
        end else begin
            kbuf[0] = 8'h57; kbuf[1] = 8'h69; kbuf[2] = 8'h6B; kbuf[3] = 8'h69;
        end
    endtask

    // Leaves the bench at the first sample point of INIT.
    task automatic load_key(input int n);
        for (int k = 0; k < n; k++) begin
            key_valid = 1'b1;
            key_in    = kbuf[k];
            tick();
            if (k == 0) chk("busy_kload", 32'(busy), 32'd1);
        end
        key_valid = 1'b0;
        key_in    = 8'h00;
        tick();
    endtask

    task automatic wait_valid(output int cnt);
        cnt = 0;
        while (!ks_valid && cnt < 3000) begin
            tick();
            cnt++;
            if (cnt == 1279) b_1279 = busy;
            if (cnt == 1280) begin b_1280 = busy; k_1280 = keyed; end
        end
        chk("wait_valid", 32'(ks_valid), 32'd1);
    endtask

    task automatic get_bytes(input int n);
        int k = 0;
        int budget = 0;
        ks_ready = 1'b1;
        while (k < n && budget < 4000) begin
            if (ks_valid) begin
                got[k] = ks_data;
                k++;
            end
            tick();
            budget++;
        end
        chk("get_bytes_count", 32'(k), 32'(n));
    endtask

    // Reference RC4 over kbuf[0..len-1]
    task automatic model(input int len, input int n);
        logic [7:0] s [256];
        logic [7:0] i, j, t;
        for (int k = 0; k < 256; k++) s[k] = 8'(k);
        j = 8'h00;
        for (int k = 0; k < 256; k++) begin
            j = j + s[k] + kbuf[k % len];
            t = s[k]; s[k] = s[j]; s[j] = t;
        end
        i = 8'h00; j = 8'h00;
        for (int m = 0; m < n; m++) begin
            i = i + 8'd1;
            j = j + s[i];
            t = s[i]; s[i] = s[j]; s[j] = t;
            t = s[i] + s[j];
            exp_ks[m] = s[t];
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c;

        // Reset state
        do_reset();
        chk("rst_ks_valid", 32'(ks_valid), 32'd0);
        chk("rst_ks_data",  32'(ks_data),  32'd0);
        chk("rst_sb_we",    32'(sb_we),    32'd0);
        chk("rst_sb_addr",  32'(sb_addr),  32'd0);
        chk("rst_sb_wdata", 32'(sb_wdata), 32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_keyed",    32'(keyed),    32'd0);
        chk("rst_state",    32'(dut.state_q), 32'(IDLE));

        // "Key": latency and first 9 bytes
        set_key_str(0);
        load_key(3);
        chk("init_we",   32'(sb_we),   32'd1);
        chk("init_addr", 32'(sb_addr), 32'd0);
        chk("init_busy", 32'(busy),    32'd1);
        wait_valid(c);
        chk("first_valid_lat", 32'(c), 32'd1286);
        get_bytes(9);
        for (int k = 0; k < 9; k++) chk($sformatf("key_ks%0d", k), 32'(got[k]), 32'(key_ks[k]));

        // Hold 10th byte, restart with ready high in the same cycle
        ks_ready = 1'b0;
        wait_valid(c);
        chk("byte10", 32'(ks_data), 32'(key_ks[9]));
        restart  = 1'b1;
        ks_ready = 1'b1;
        tick();
        restart  = 1'b0;
        chk("restart_valid", 32'(ks_valid), 32'd0);
        chk("restart_busy",  32'(busy),     32'd1);
        chk("restart_keyed", 32'(keyed),    32'd0);
        wait_valid(c);
        chk("restart_lat", 32'(c), 32'd1286);
        get_bytes(9);
        for (int k = 0; k < 9; k++) chk($sformatf("rekey_ks%0d", k), 32'(got[k]), 32'(key_ks[k]));

        // "Wiki" plus busy/keyed boundary at end of KSA
        do_reset();
        set_key_str(1);
        load_key(4);
        wait_valid(c);
        chk("busy_last_ksa", 32'(b_1279), 32'd1);
        chk("busy_prga",     32'(b_1280), 32'd0);
        chk("keyed_prga",    32'(k_1280), 32'd1);
        get_bytes(5);
        for (int k = 0; k < 5; k++) chk($sformatf("wiki_ks%0d", k), 32'(got[k]), 32'(wiki_ks[k]));

        // Back-pressure: 20 stalled cycles
        do_reset();
        set_key_str(0);
        load_key(3);
        ks_ready = 1'b0;
        wait_valid(c);
        for (int k = 0; k < 20; k++) begin
            chk("stall_valid", 32'(ks_valid), 32'd1);
            chk("stall_data",  32'(ks_data),  32'hEB);
            chk("stall_we",    32'(sb_we),    32'd0);
            tick();
        end
        get_bytes(2);
        chk("stall_b0", 32'(got[0]), 32'hEB);
        chk("stall_b1", 32'(got[1]), 32'h9F);

        // 40-byte key saturates at 32
        do_reset();
        for (int k = 0; k < 40; k++) kbuf[k] = 8'(k * 37 + 11);
        load_key(40);
        chk("key_len_sat", 32'(dut.u_keybuf.len_q), 32'd32);
        model(32, 8);
        wait_valid(c);
        get_bytes(8);
        for (int k = 0; k < 8; k++) chk($sformatf("long_ks%0d", k), 32'(got[k]), 32'(exp_ks[k]));

        // Reset mid-KSA
        do_reset();
        set_key_str(0);
        load_key(3);
        for (int k = 0; k < 700; k++) tick();
        chk("mid_ksa_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        chk("midrst_state",  32'(dut.state_q), 32'(IDLE));
        chk("midrst_busy",   32'(busy),     32'd0);
        chk("midrst_we",     32'(sb_we),    32'd0);
        chk("midrst_addr",   32'(sb_addr),  32'd0);
        chk("midrst_valid",  32'(ks_valid), 32'd0);
        chk("midrst_keylen", 32'(dut.u_keybuf.len_q), 32'd0);
        rst = 1'b0;
        load_key(3);
        wait_valid(c);
        get_bytes(1);
        chk("midrst_first", 32'(got[0]), 32'hEB);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
